stopwatch_counter: RTL

- Downstream consumer of the 7-bit divided-clock bus from the system clock divider.
- Runs entirely in the sys_clock domain. It selects one divided clock bit, synchronizes it, and edge-detects it into a single-cycle tick.
- Tick drives a BCD stopwatch (MM:SS.cc) with a start/stop/clear control FSM.
- BCD digit outputs feed the seven-segment display driver.

---
 rtl/stopwatch_counter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD MM:SS.cc stopwatch ticked by one bit of the divider clock bus.
// Latency: a source rise sampled at edge k gives a tick after edge k+SYNC_STAGES-1; digits update at edge k+SYNC_STAGES.
// Backpressure: none; ticks and command pulses are consumed in the cycle they arrive.
//
// Ports:
//   sys_clock, reset     : clock and synchronous active-high reset
//   clock_bus[6:0]       : divided clocks {1MHz,100kHz,10kHz,1kHz,100Hz,10Hz,1Hz}, async to sys_clock
//   start_stop/clear/lap : single-cycle command pulses
//   digits[23:0]         : {min_t,min_u,sec_t,sec_u,cs_t,cs_u}, BCD
//   running              : high while RUNNING
//   wrap                 : one-cycle pulse on 59:59.99 -> 00:00.00
//   lap_active           : high while the display is frozen
// Optional build macro: STOPWATCH_LAP_HOLD_EN enables the lap hold display.
//   Without it lap is ignored, lap_active is 0 and digits is always the live count.

module stopwatch_counter #(
  parameter int TICK_BIT    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic [6:0]  clock_bus,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] digits,
  output logic        running,
  output logic        wrap,
  output logic        lap_active
);

  // Per-digit maximum, least significant digit in the low nibble.
  localparam logic [23:0] DIGIT_MAX = 24'h595999;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     prev_q;
  logic                     tick;
  logic                     count_en;
  logic                     at_max;
  logic [23:0]              count;
  logic [23:0]              count_inc;
  logic [23:0]              count_next;

  // Only the selected bus bit is used; the rest of the bus is intentionally dropped.
  logic [6:0] bus_unused;
  assign bus_unused = clock_bus;

  // Rising edge of the synchronized source, one cycle wide.
  assign tick     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign count_en = tick && (state == ST_RUNNING);
  assign at_max   = (count == DIGIT_MAX);

  // Full ripple of carries in one cycle so digits never show a partial carry.
  always_comb begin
    logic carry;
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (count[i*4 +: 4] == DIGIT_MAX[i*4 +: 4]) begin
          count_inc[i*4 +: 4] = 4'd0;
        end else begin
          count_inc[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  assign count_next = count_en ? count_inc : count;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic [23:0] hold;
  assign digits = lap_active ? hold : count;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign digits     = count;
  assign lap_active = 1'b0;
`endif

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state   <= ST_IDLE;
      running <= 1'b0;
      wrap    <= 1'b0;
      count   <= '0;
`ifdef STOPWATCH_LAP_HOLD_EN
      lap_active <= 1'b0;
      hold       <= '0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clock_bus[TICK_BIT]};
      prev_q <= sync_q[SYNC_STAGES-1];

      if (clear) begin
        // clear wins over every other same-cycle input.
        state   <= ST_IDLE;
        running <= 1'b0;
        wrap    <= 1'b0;
        count   <= '0;
`ifdef STOPWATCH_LAP_HOLD_EN
        lap_active <= 1'b0;
`endif
      end else begin
        // Ticks count only in RUNNING as seen before this edge, so the
        // start_stop that leaves RUNNING still lets its tick through.
        count <= count_next;
        wrap  <= count_en & at_max;

        if (start_stop) begin
          case (state)
            ST_IDLE: begin
              state   <= ST_RUNNING;
              running <= 1'b1;
            end
            ST_RUNNING: begin
              state   <= ST_PAUSED;
              running <= 1'b0;
            end
            ST_PAUSED: begin
              state   <= ST_RUNNING;
              running <= 1'b1;
            end
            default: begin
              state   <= ST_IDLE;
              running <= 1'b0;
            end
          endcase
        end

`ifdef STOPWATCH_LAP_HOLD_EN
        if (lap) begin
          if (lap_active && (state != ST_IDLE)) begin
            lap_active <= 1'b0;
          end else if (!lap_active && (state == ST_RUNNING)) begin
            // Capture includes any increment happening on this same edge.
            hold       <= count_next;
            lap_active <= 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule
